// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-mix profiler.
//   - Opcode constants for the classes the classifier recognises.
//   - Read-select encodings for the snapshot read port.
//   - State typedefs for the control FSM and the read FSM.
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // One counter per instruction class plus a running total.
    localparam int NUM_CNT = 4;

    typedef enum logic [1:0] {
        SEL_I   = 2'd0,
        SEL_R   = 2'd1,
        SEL_J   = 2'd2,
        SEL_TOT = 2'd3
    } rd_sel_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } ctrl_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

endpackage

// File: rtl/instr_mix_counter_ctrl_statistics.sv
// ---------------------------------------------------------------------------
// statistics
// Combinational opcode classifier. Exactly one output is high for any op.
// Ports:
//   op  in  6  opcode of the instruction
//   i   out 1  immediate-class instruction (everything that is not R or J)
//   r   out 1  R-type instruction (opcode 0x00)
//   j   out 1  jump instruction (J or JAL)
// ---------------------------------------------------------------------------
module statistics
    import mips_pkg::*;
(
    input  logic [5:0] op,
    output logic       i,
    output logic       r,
    output logic       j
);

    assign r = (op == OP_RTYPE);
    assign j = (op == OP_J) || (op == OP_JAL);
    assign i = !r && !j;

endmodule

// File: rtl/instr_mix_counter_ctrl.sv
// ---------------------------------------------------------------------------
// instr_mix_counter_ctrl
// Profiles retired instructions by class (I/R/J) plus a total count, with
// run/stop control, synchronous clear and a req/ack snapshot read port.
// Ports:
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      synchronous reset, active low
//   op           in   6      opcode of the retiring instruction
//   instr_valid  in   1      op is a retired instruction this cycle
//   start        in   1      pulse: begin counting
//   stop         in   1      pulse: stop counting (wins over start)
//   clr          in   1      pulse: zero all counters and ovf
//   rd_req       in   1      read request, accepted only in R_IDLE
//   rd_sel       in   2      0=I, 1=R, 2=J, 3=total
//   rd_ack       out  1      one-cycle pulse, rd_data valid
//   rd_data      out  CNT_W  snapshot of the selected counter
//   running      out  1      1 while counting is enabled
//   ovf          out  1      sticky overflow/saturation flag
// ---------------------------------------------------------------------------
module instr_mix_counter_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             instr_valid,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             rd_req,
    input  logic [1:0]       rd_sel,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic             running,
    output logic             ovf
);

    // Returns {flag, next}. flag marks the event that makes ovf sticky:
    // reaching all-ones when saturating, or wrapping past all-ones otherwise.
    function automatic logic [CNT_W:0] cnt_incr(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] all_ones;
        logic [CNT_W-1:0] nxt;
        logic             flag;
        all_ones = '1;
        if (val == all_ones) begin
            nxt  = SAT_EN ? val : '0;
            flag = 1'b1;
        end else begin
            nxt  = val + 1'b1;
            flag = SAT_EN && (nxt == all_ones);
        end
        return {flag, nxt};
    endfunction

    logic cls_i, cls_r, cls_j;

    statistics u_statistics (
        .op (op),
        .i  (cls_i),
        .r  (cls_r),
        .j  (cls_j)
    );

    ctrl_state_e      ctrl_state_q;
    rd_state_e        rd_state_q;
    logic             running_q;
    logic             ovf_q;
    logic             rd_ack_q;
    logic [CNT_W-1:0] rd_data_q;

    logic [NUM_CNT-1:0] hit;
    logic [NUM_CNT-1:0] ovf_hit;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];
    logic               count_en;

    // Map classifier outputs onto counter slots by read-select encoding.
    always_comb begin
        hit          = '0;
        hit[SEL_I]   = cls_i;
        hit[SEL_R]   = cls_r;
        hit[SEL_J]   = cls_j;
        hit[SEL_TOT] = 1'b1;
    end

    // Uses the registered state, so an instruction in the start cycle is
    // dropped and one in the stop cycle is still counted.
    assign count_en = (ctrl_state_q == S_RUN) && instr_valid;

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic [CNT_W:0]   inc_res;

            assign inc_res     = cnt_incr(cnt_q);
            assign cnt_d       = (count_en && hit[gi]) ? inc_res[CNT_W-1:0] : cnt_q;
            assign ovf_hit[gi] = count_en && hit[gi] && inc_res[CNT_W];
            assign cnt_val[gi] = cnt_q;

            // clr has priority over a same-cycle increment.
            always_ff @(posedge clk) begin
                if (!rst_n || clr) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_state_q <= S_IDLE;
            running_q    <= 1'b0;
            rd_state_q   <= R_IDLE;
            rd_ack_q     <= 1'b0;
            rd_data_q    <= '0;
            ovf_q        <= 1'b0;
        end else begin
            case (ctrl_state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        ctrl_state_q <= S_RUN;
                        running_q    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        ctrl_state_q <= S_IDLE;
                        running_q    <= 1'b0;
                    end
                end
                default: begin
                    ctrl_state_q <= S_IDLE;
                    running_q    <= 1'b0;
                end
            endcase

            if (clr) begin
                ovf_q <= 1'b0;
            end else if (|ovf_hit) begin
                ovf_q <= 1'b1;
            end

            // Snapshot is the pre-increment, pre-clear register value.
            case (rd_state_q)
                R_IDLE: begin
                    if (rd_req) begin
                        rd_state_q <= R_RESP;
                        rd_ack_q   <= 1'b1;
                        rd_data_q  <= cnt_val[rd_sel];
                    end
                end
                R_RESP: begin
                    rd_state_q <= R_IDLE;
                    rd_ack_q   <= 1'b0;
                end
                default: begin
                    rd_state_q <= R_IDLE;
                    rd_ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rd_ack  = rd_ack_q;
    assign rd_data = rd_data_q;
    assign running = running_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_instr_mix_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_mix_counter_ctrl
// Drives three instances with shared stimulus: 32-bit saturating, 8-bit
// saturating and 8-bit wrapping. Read responses are checked by a scoreboard
// monitor; control and flag behaviour is checked inline in each test task.
// ---------------------------------------------------------------------------
module tb_instr_mix_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       instr_valid;
    logic       start;
    logic       stop;
    logic       clr;
    logic       rd_req;
    logic [1:0] rd_sel;

    logic        rd_ack32, running32, ovf32;
    logic [31:0] rd_data32;
    logic        rd_ack8s, running8s, ovf8s;
    logic [7:0]  rd_data8s;
    logic        rd_ack8w, running8w, ovf8w;
    logic [7:0]  rd_data8w;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] e32;
        logic [7:0]  e8s;
        logic [7:0]  e8w;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    instr_mix_counter_ctrl #(.CNT_W(32), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .instr_valid(instr_valid),
        .start(start), .stop(stop), .clr(clr), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_ack(rd_ack32), .rd_data(rd_data32), .running(running32), .ovf(ovf32)
    );

    instr_mix_counter_ctrl #(.CNT_W(8), .SAT_EN(1'b1)) dut8s (
        .clk(clk), .rst_n(rst_n), .op(op), .instr_valid(instr_valid),
        .start(start), .stop(stop), .clr(clr), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_ack(rd_ack8s), .rd_data(rd_data8s), .running(running8s), .ovf(ovf8s)
    );

    instr_mix_counter_ctrl #(.CNT_W(8), .SAT_EN(1'b0)) dut8w (
        .clk(clk), .rst_n(rst_n), .op(op), .instr_valid(instr_valid),
        .start(start), .stop(stop), .clr(clr), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_ack(rd_ack8w), .rd_data(rd_data8w), .running(running8w), .ovf(ovf8w)
    );

    // Scoreboard monitor: every ack pops one expected entry.
    always @(negedge clk) begin
        if (rd_ack32 || rd_ack8s || rd_ack8w) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_ack: ack32=%0b ack8s=%0b ack8w=%0b, required no ack",
                         rd_ack32, rd_ack8s, rd_ack8w);
            end else begin
                mon_e = sb.pop_front();
                if (rd_ack32 !== 1'b1 || rd_data32 !== mon_e.e32) begin
                    tests_failed++;
                    $display("FAIL read32: ack=%0b data=%0d, required ack=1 data=%0d",
                             rd_ack32, rd_data32, mon_e.e32);
                end
                tests_run++;
                if (rd_ack8s !== 1'b1 || rd_data8s !== mon_e.e8s) begin
                    tests_failed++;
                    $display("FAIL read8s: ack=%0b data=%0d, required ack=1 data=%0d",
                             rd_ack8s, rd_data8s, mon_e.e8s);
                end
                tests_run++;
                if (rd_ack8w !== 1'b1 || rd_data8w !== mon_e.e8w) begin
                    tests_failed++;
                    $display("FAIL read8w: ack=%0b data=%0d, required ack=1 data=%0d",
                             rd_ack8w, rd_data8w, mon_e.e8w);
                end
                $display("[TB] read: data32=%0d data8s=%0d data8w=%0d", rd_data32, rd_data8s, rd_data8w);
            end
        end
    end

    // Stimulus helpers (no checking).
    task automatic pulse_ctrl(input logic s, input logic p, input logic vld, input logic [5:0] opc);
        @(negedge clk);
        start = s; stop = p; instr_valid = vld; op = opc;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; instr_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic retire_n(input logic [5:0] opc, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            instr_valid = 1'b1; op = opc;
        end
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    // Issue one read (optionally with a same-cycle op and clr) and wait for the scoreboard to drain.
    task automatic issue_read(input logic [1:0] sel, input logic vld, input logic [5:0] opc,
                              input logic c, input logic [31:0] e32,
                              input logic [7:0] e8s, input logic [7:0] e8w);
        exp_t e;
        int   k;
        e.e32 = e32; e.e8s = e8s; e.e8w = e8w;
        @(negedge clk);
        rd_req = 1'b1; rd_sel = sel; instr_valid = vld; op = opc; clr = c;
        sb.push_back(e);
        @(negedge clk);
        rd_req = 1'b0; instr_valid = 1'b0; clr = 1'b0;
        #1;
        k = 0;
        while (sb.size() != 0 && k < 4) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL read_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = '0; instr_valid = 1'b0; start = 1'b0; stop = 1'b0;
        clr = 1'b0; rd_req = 1'b0; rd_sel = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({running32, ovf32, rd_ack32} !== 3'b000 || rd_data32 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset32: run=%0b ovf=%0b ack=%0b data=%0d, required all 0",
                     running32, ovf32, rd_ack32, rd_data32);
        end
        tests_run++;
        if ({running8s, ovf8s, rd_ack8s, running8w, ovf8w, rd_ack8w} !== 6'b0
            || rd_data8s !== 8'd0 || rd_data8w !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset8: flags8s=%0b%0b%0b flags8w=%0b%0b%0b, required all 0",
                     running8s, ovf8s, rd_ack8s, running8w, ovf8w, rd_ack8w);
        end
        rst_n = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_count();
        logic [5:0] ops [6];
        ops = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h23, 6'h2B};
        pulse_ctrl(1'b1, 1'b0, 1'b0, 6'h00);
        tests_run++;
        if (running32 !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_running: running=%0b, required 1", running32);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            instr_valid = 1'b1; op = ops[k];
        end
        @(negedge clk);
        instr_valid = 1'b0;
        issue_read(2'd0, 1'b0, 6'h00, 1'b0, 32'd3, 8'd3, 8'd3);
        issue_read(2'd1, 1'b0, 6'h00, 1'b0, 32'd1, 8'd1, 8'd1);
        issue_read(2'd2, 1'b0, 6'h00, 1'b0, 32'd2, 8'd2, 8'd2);
        issue_read(2'd3, 1'b0, 6'h00, 1'b0, 32'd6, 8'd6, 8'd6);
        tests_run++;
        if (ovf32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL count_ovf: ovf=%0b, required 0", ovf32);
        end
    endtask

    task automatic test_stop();
        pulse_ctrl(1'b0, 1'b1, 1'b0, 6'h00);
        tests_run++;
        if (running32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_running: running=%0b, required 0", running32);
        end
        retire_n(6'h08, 5);
        issue_read(2'd3, 1'b0, 6'h00, 1'b0, 32'd6, 8'd6, 8'd6);
        pulse_ctrl(1'b1, 1'b1, 1'b0, 6'h00);
        tests_run++;
        if (running32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_stop_same: running=%0b, required 0", running32);
        end
    endtask

    task automatic test_read_during_count();
        pulse_ctrl(1'b1, 1'b0, 1'b0, 6'h00);
        issue_read(2'd3, 1'b1, 6'h08, 1'b0, 32'd6, 8'd6, 8'd6);
        issue_read(2'd3, 1'b0, 6'h00, 1'b0, 32'd7, 8'd7, 8'd7);
    endtask

    task automatic test_overflow();
        pulse_clr();
        retire_n(6'h00, 260);
        issue_read(2'd1, 1'b0, 6'h00, 1'b0, 32'd260, 8'd255, 8'd4);
        issue_read(2'd3, 1'b0, 6'h00, 1'b0, 32'd260, 8'd255, 8'd4);
        tests_run++;
        if ({ovf32, ovf8s, ovf8w} !== 3'b011) begin
            tests_failed++;
            $display("FAIL overflow_flags: ovf32/8s/8w=%0b%0b%0b, required 011", ovf32, ovf8s, ovf8w);
        end
    endtask

    task automatic test_clr_read();
        pulse_clr();
        tests_run++;
        if ({ovf32, ovf8s, ovf8w} !== 3'b000) begin
            tests_failed++;
            $display("FAIL clr_ovf: ovf32/8s/8w=%0b%0b%0b, required 000", ovf32, ovf8s, ovf8w);
        end
        retire_n(6'h08, 3);
        issue_read(2'd0, 1'b1, 6'h08, 1'b1, 32'd3, 8'd3, 8'd3);
        for (int s = 0; s < 4; s++) begin
            issue_read(s[1:0], 1'b0, 6'h00, 1'b0, 32'd0, 8'd0, 8'd0);
        end
        tests_run++;
        if ({ovf32, ovf8s, ovf8w} !== 3'b000) begin
            tests_failed++;
            $display("FAIL clr_ovf_after: ovf32/8s/8w=%0b%0b%0b, required 000", ovf32, ovf8s, ovf8w);
        end
    endtask

    task automatic test_start_stop_edges();
        pulse_ctrl(1'b0, 1'b1, 1'b1, 6'h08);
        tests_run++;
        if (running32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL edge_stop: running=%0b, required 0", running32);
        end
        pulse_ctrl(1'b1, 1'b0, 1'b1, 6'h00);
        tests_run++;
        if (running32 !== 1'b1) begin
            tests_failed++;
            $display("FAIL edge_start: running=%0b, required 1", running32);
        end
        issue_read(2'd3, 1'b0, 6'h00, 1'b0, 32'd1, 8'd1, 8'd1);
        issue_read(2'd0, 1'b0, 6'h00, 1'b0, 32'd1, 8'd1, 8'd1);
        issue_read(2'd1, 1'b0, 6'h00, 1'b0, 32'd0, 8'd0, 8'd0);
    endtask

    task automatic test_reset_mid();
        retire_n(6'h00, 2);
        @(negedge clk);
        rd_req = 1'b1; rd_sel = 2'd3; rst_n = 1'b0;
        @(negedge clk);
        rd_req = 1'b0;
        tests_run++;
        if (rd_ack32 !== 1'b0 || running32 !== 1'b0 || rd_data32 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: ack=%0b run=%0b data=%0d, required 0 0 0",
                     rd_ack32, running32, rd_data32);
        end
        @(negedge clk);
        tests_run++;
        if (rd_ack32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_ack: ack=%0b, required 0", rd_ack32);
        end
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            issue_read(s[1:0], 1'b0, 6'h00, 1'b0, 32'd0, 8'd0, 8'd0);
        end
        tests_run++;
        if (running32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_running: running=%0b, required 0", running32);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_stop();
        test_read_during_count();
        test_overflow();
        test_clr_read();
        test_start_stop_edges();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
